axi_burst_scheduler: RTL and testbench

- Command-level sequencer in front of axi_burst_master.
- Accepts one transfer command (direction, start address, total beat count) and splits it into AXI-legal bursts:
  - no more than MAX_BEATS beats per burst;
  - no burst crosses a 4 KB boundary.
- Drives the burst master's user_start / user_w_r / user_burst_len_in / user_addr_in one burst at a time, handshaking on user_free.
- Aggregates per-burst responses into one completion pulse with a worst-case status.

---
 rtl/axi_burst_pkg.sv | 25 ++
 rtl/axi_burst_splitter_calc.sv | 30 +++
 rtl/axi_burst_scheduler.sv | 127 ++++++++++++
 tb/tb_axi_burst_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// Shared definitions for the AXI burst scheduler: response codes, 4 KB boundary,
// FSM state encoding and the worst-response merge.
package axi_burst_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int BOUNDARY = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Severity order matches the numeric encoding, so worst is a plain max.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_splitter_calc.sv
// Next burst size: min(remaining, MAX_BEATS, beats left before the 4 KB boundary).
module axi_burst_splitter_calc
    import axi_burst_pkg::*;
#(
    parameter int BSHIFT    = 3,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic [11:0]      addr_lo,
    input  logic [CNT_W-1:0] remaining,
    output logic [CNT_W:0]   nb
);

    localparam int CW = CNT_W + 1;

    logic [12:0]   room;
    logic [CW-1:0] rem_x;
    logic [CW-1:0] max_x;
    logic [CW-1:0] room_x;
    logic [CW-1:0] m1;

    // addr_lo==0 yields the full 4 KB window, never 0.
    assign room   = (13'(BOUNDARY) - {1'b0, addr_lo}) >> BSHIFT;
    assign rem_x  = {1'b0, remaining};
    assign max_x  = CW'(MAX_BEATS);
    assign room_x = CW'(room);
    assign m1     = (rem_x < max_x) ? rem_x : max_x;
    assign nb     = (m1 < room_x) ? m1 : room_x;

endmodule

// File: rtl/axi_burst_scheduler.sv
// Splits one transfer command into AXI-legal bursts for axi_burst_master and
// reports a single completion with the worst response seen.
module axi_burst_scheduler
    import axi_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_w_r,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_beats,
    output logic              cmd_err,
    output logic              done,
    output logic [1:0]        done_status,
    output logic              busy,
    output logic              mst_start,
    output logic              mst_w_r,
    output logic [7:0]        mst_burst_len,
    output logic [ADDR_W-1:0] mst_addr,
    input  logic              mst_free,
    input  logic [1:0]        mst_status,
    input  logic              mst_status_en
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BSHIFT = $clog2(BYTES);

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  rem_r;
    logic              wr_r;
    logic [CNT_W:0]    nb_r;
    logic [1:0]        worst;
    logic [CNT_W:0]    nb_calc;
    logic [1:0]        worst_next;
    logic              misaligned;

    axi_burst_splitter_calc #(
        .BSHIFT    (BSHIFT),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_calc (
        .addr_lo   (addr_r[11:0]),
        .remaining (rem_r),
        .nb        (nb_calc)
    );

    assign cmd_ready  = (state == ST_IDLE);
    assign misaligned = |(cmd_addr & ADDR_W'(BYTES - 1));
    assign worst_next = mst_status_en ? worst_resp(worst, mst_status) : worst;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            addr_r        <= '0;
            rem_r         <= '0;
            wr_r          <= 1'b0;
            nb_r          <= '0;
            worst         <= RESP_OKAY;
            cmd_err       <= 1'b0;
            done          <= 1'b0;
            done_status   <= RESP_OKAY;
            busy          <= 1'b0;
            mst_start     <= 1'b0;
            mst_w_r       <= 1'b0;
            mst_burst_len <= '0;
            mst_addr      <= '0;
        end else begin
            cmd_err <= 1'b0;
            done    <= 1'b0;
            if (state != ST_IDLE)
                worst <= worst_next;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (misaligned) begin
                            cmd_err <= 1'b1;
                        end else begin
                            addr_r      <= cmd_addr;
                            rem_r       <= cmd_beats;
                            wr_r        <= cmd_w_r;
                            worst       <= RESP_OKAY;
                            done_status <= RESP_OKAY;
                            busy        <= 1'b1;
                            state       <= (cmd_beats == '0) ? ST_DONE : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    nb_r          <= nb_calc;
                    mst_burst_len <= 8'(nb_calc - (CNT_W+1)'(1));
                    mst_addr      <= addr_r;
                    mst_w_r       <= wr_r;
                    mst_start     <= 1'b1;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // The master signals acceptance by dropping user_free.
                    if (!mst_free) begin
                        mst_start <= 1'b0;
                        addr_r    <= addr_r + (ADDR_W'(nb_r) << BSHIFT);
                        rem_r     <= rem_r - CNT_W'(nb_r);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mst_free)
                        state <= (rem_r == '0) ? ST_DONE : ST_CALC;
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    done_status <= worst_next;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Directed bench: a simple burst-master responder records issued bursts and
// returns per-burst responses from a table.
module tb_axi_burst_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_w_r;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        cmd_err;
    logic        done;
    logic [1:0]  done_status;
    logic        busy;
    logic        mst_start;
    logic        mst_w_r;
    logic [7:0]  mst_burst_len;
    logic [31:0] mst_addr;
    logic        mst_free;
    logic [1:0]  mst_status;
    logic        mst_status_en;

    logic        slave_en;
    logic        s_free;
    logic        m_free;
    logic [1:0]  resp_tab [64];
    logic [7:0]  q_len  [$];
    logic [31:0] q_addr [$];
    logic        q_wr   [$];

    int n_cmp = 0;
    int n_err = 0;

    assign mst_free = slave_en ? s_free : m_free;

    always #5 aclk = ~aclk;

    axi_burst_scheduler #(
        .ADDR_W(32), .DATA_W(64), .MAX_BEATS(256), .CNT_W(16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_w_r       (cmd_w_r),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .cmd_err       (cmd_err),
        .done          (done),
        .done_status   (done_status),
        .busy          (busy),
        .mst_start     (mst_start),
        .mst_w_r       (mst_w_r),
        .mst_burst_len (mst_burst_len),
        .mst_addr      (mst_addr),
        .mst_free      (mst_free),
        .mst_status    (mst_status),
        .mst_status_en (mst_status_en)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Burst master stand-in: accepts after one cycle, completes 3 cycles later
    // with the response taken from resp_tab, coincident with user_free rising.
    initial begin : slave
        s_free        = 1'b1;
        mst_status    = 2'd0;
        mst_status_en = 1'b0;
        forever begin
            @(posedge aclk); #1;
            mst_status_en = 1'b0;
            mst_status    = 2'd0;
            if (slave_en && mst_start && s_free) begin
                int bidx;
                bidx = q_len.size();
                q_len.push_back(mst_burst_len);
                q_addr.push_back(mst_addr);
                q_wr.push_back(mst_w_r);
                s_free = 1'b0;
                repeat (3) @(posedge aclk);
                #1;
                s_free        = 1'b1;
                mst_status_en = 1'b1;
                mst_status    = resp_tab[bidx];
            end
        end
    end

    task automatic send(input logic wr, input logic [31:0] a, input logic [15:0] b);
        cmd_w_r   = wr;
        cmd_addr  = a;
        cmd_beats = b;
        cmd_valid = 1'b1;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            @(posedge aclk); #1;
        end
    endtask

    initial begin : main
        int base;
        logic seen;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_w_r   = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        slave_en  = 1'b1;
        m_free    = 1'b1;
        for (int i = 0; i < 64; i++) resp_tab[i] = 2'd0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_start", mst_start, 0);
        chk("rst_addr", mst_addr, 0);
        chk("rst_len", mst_burst_len, 0);
        chk("rst_status", done_status, 0);
        chk("rst_ready", cmd_ready, 1);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Write crossing a 4 KB boundary: 2 beats before it, 2 after.
        base = q_len.size();
        send(1'b0, 32'h0000_0FF0, 16'd4);
        chk("t1_busy", busy, 1);
        chk("t1_ready", cmd_ready, 0);
        wait_done();
        chk("t1_done", done, 1);
        chk("t1_status", done_status, 0);
        chk("t1_nburst", q_len.size() - base, 2);
        chk("t1_len0", q_len[base], 8'd1);
        chk("t1_addr0", q_addr[base], 32'h0FF0);
        chk("t1_wr0", q_wr[base], 0);
        chk("t1_len1", q_len[base+1], 8'd1);
        chk("t1_addr1", q_addr[base+1], 32'h1000);
        @(posedge aclk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // Read of 600 beats: 256 / 256 / 88.
        base = q_len.size();
        send(1'b1, 32'h0, 16'd600);
        wait_done();
        chk("t2_done", done, 1);
        chk("t2_status", done_status, 0);
        chk("t2_nburst", q_len.size() - base, 3);
        chk("t2_len0", q_len[base], 8'd255);
        chk("t2_addr0", q_addr[base], 32'h0);
        chk("t2_wr0", q_wr[base], 1);
        chk("t2_len1", q_len[base+1], 8'd255);
        chk("t2_addr1", q_addr[base+1], 32'h800);
        chk("t2_len2", q_len[base+2], 8'd87);
        chk("t2_addr2", q_addr[base+2], 32'h1000);
        @(posedge aclk); #1;

        // Misaligned address is rejected without any burst.
        base = q_len.size();
        send(1'b0, 32'h0000_0004, 16'd4);
        chk("t3_err", cmd_err, 1);
        chk("t3_busy", busy, 0);
        seen = mst_start;
        @(posedge aclk); #1;
        chk("t3_err_pulse", cmd_err, 0);
        for (int i = 0; i < 5; i++) begin
            seen = seen | mst_start | busy;
            @(posedge aclk); #1;
        end
        chk("t3_no_start", seen, 0);
        chk("t3_nburst", q_len.size() - base, 0);

        // Zero-beat command completes without touching the master.
        base = q_len.size();
        send(1'b0, 32'h0000_0200, 16'd0);
        chk("t4_done_early", done, 0);
        chk("t4_busy", busy, 1);
        @(posedge aclk); #1;
        chk("t4_done", done, 1);
        chk("t4_status", done_status, 0);
        chk("t4_start", mst_start, 0);
        chk("t4_nburst", q_len.size() - base, 0);
        @(posedge aclk); #1;

        // SLVERR in the middle burst.
        base = q_len.size();
        resp_tab[base+1] = 2'd2;
        send(1'b1, 32'h0, 16'd600);
        wait_done();
        chk("t5_done", done, 1);
        chk("t5_status", done_status, 2);
        @(posedge aclk); #1;

        // DECERR on the last burst, arriving with the final user_free rise.
        base = q_len.size();
        resp_tab[base+2] = 2'd3;
        send(1'b1, 32'h0, 16'd600);
        wait_done();
        chk("t6_done", done, 1);
        chk("t6_status", done_status, 3);
        chk("t6_nburst", q_len.size() - base, 3);
        @(posedge aclk); #1;
        chk("t6_status_hold", done_status, 3);

        // Master stays busy: request held, then reset in the WAIT state.
        slave_en = 1'b0;
        m_free   = 1'b1;
        send(1'b0, 32'h0000_0100, 16'd8);
        for (int i = 0; i < 10; i++) begin
            if (mst_start) break;
            @(posedge aclk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t7_hold_start%0d", i), mst_start, 1);
            chk($sformatf("t7_hold_addr%0d", i), mst_addr, 32'h100);
            chk($sformatf("t7_hold_len%0d", i), mst_burst_len, 8'd7);
            @(posedge aclk); #1;
        end
        m_free = 1'b0;
        @(posedge aclk); #1;
        chk("t7_wait_start", mst_start, 0);
        chk("t7_wait_busy", busy, 1);
        chk("t7_wait_addr", mst_addr, 32'h100);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t7_rst_start", mst_start, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_addr", mst_addr, 0);
        chk("t7_rst_len", mst_burst_len, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_ready", cmd_ready, 1);
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        m_free   = 1'b1;
        slave_en = 1'b1;
        @(posedge aclk); #1;
        chk("t7_post_done", done, 0);
        chk("t7_post_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
